// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default geometry, FSM state
// encodings and the word-alignment constant applied to memory addresses.
package icache_pkg;

    localparam int ICACHE_ADDR_BITS  = 18;
    localparam int ICACHE_INDEX_BITS = 7;

    localparam logic [1:0] WORD_ALIGN = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Handshake bundles around the cache: the fetch-stage side and the memory
// controller's instruction port.
interface icache_fetch_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic [31:0] if_inst;
    logic        if_done;

    modport master (output if_req, if_addr, flush, input if_inst, if_done);
    modport slave  (input if_req, if_addr, flush, output if_inst, if_done);
endinterface

interface icache_mem_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        mem_done;

    modport master (output mem_req, mem_addr, input mem_inst, mem_done);
    modport slave  (input mem_req, mem_addr, output mem_inst, mem_done);
endinterface

// File: rtl/icache_array.sv
// Tag/data/valid storage for a direct-mapped, one-word-per-line cache.
// Combinational read, synchronous write; only the valid bits are reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = ICACHE_ADDR_BITS - ICACHE_INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [31:0]           rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [31:0]           wr_data_i
);
    localparam int LINES = 2 ** INDEX_BITS;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];
    logic [LINES-1:0]    valid_q;

    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, single-word fills from the
// memory controller, flush-while-filling support and hit/miss counters.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_BITS  = ICACHE_ADDR_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    icache_fetch_if.slave       fetch,
    icache_mem_if.master        mem,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    icache_state_e   state_q;
    logic            drop_q;
    logic            if_done_q;
    logic [31:0]     if_inst_q;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     hit_cnt_q;
    logic [31:0]     miss_cnt_q;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  rd_valid;
    logic                  hit;
    logic                  fill_we;
    logic [1:0]            unused_addr_lsb;

    assign lk_idx          = fetch.if_addr[INDEX_BITS+1:2];
    assign lk_tag          = fetch.if_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign hit             = rd_valid && (rd_tag == lk_tag);
    assign unused_addr_lsb = fetch.if_addr[1:0];

    // The latched miss address doubles as the fill index/tag.
    assign fill_we = rdy && (state_q == MISS) && mem.mem_done;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (lk_idx),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .we_i       (fill_we),
        .wr_idx_i   (mem_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (mem_addr_q[ADDR_BITS-1:INDEX_BITS+2]),
        .wr_data_i  (mem.mem_inst)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            drop_q     <= 1'b0;
            if_done_q  <= 1'b0;
            if_inst_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy) begin
            if_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A pending if_done blocks lookup so done never repeats.
                    if (!if_done_q && !fetch.flush && fetch.if_req) begin
                        if (hit) begin
                            if_inst_q <= rd_data;
                            if_done_q <= 1'b1;
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {fetch.if_addr[31:2], WORD_ALIGN};
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                            state_q    <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem.mem_done) begin
                        mem_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        state_q   <= IDLE;
                        if (!drop_q && !fetch.flush) begin
                            if_inst_q <= mem.mem_inst;
                            if_done_q <= 1'b1;
                        end
                    end else if (fetch.flush) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fetch.if_inst = if_inst_q;
    assign fetch.if_done = if_done_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = mem_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflicts, flush, stall, reset.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    int          checks;
    int          errors;

    icache_fetch_if fif ();
    icache_mem_if   mif ();

    icache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .fetch    (fif),
        .mem      (mif),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Miss on a, hold request 4 cycles, return d; expects a delivered word.
    task automatic do_fill(input logic [31:0] a, input logic [31:0] d, input logic [31:0] mc);
        logic [31:0] wa;
        wa = a;
        wa[1:0] = 2'b00;
        fif.if_req  = 1'b1;
        fif.if_addr = a;
        step();
        check("miss mem_req", 32'(mif.mem_req), 32'd1);
        check("miss mem_addr", mif.mem_addr, wa);
        check("miss miss_cnt", miss_cnt, mc);
        step(); step(); step();
        check("miss mem_req held", 32'(mif.mem_req), 32'd1);
        check("miss no early done", 32'(fif.if_done), 32'd0);
        mif.mem_inst = d;
        mif.mem_done = 1'b1;
        step();
        mif.mem_done = 1'b0;
        fif.if_req   = 1'b0;
        check("fill if_done", 32'(fif.if_done), 32'd1);
        check("fill if_inst", fif.if_inst, d);
        check("fill mem_req drop", 32'(mif.mem_req), 32'd0);
        step();
        check("fill done pulse", 32'(fif.if_done), 32'd0);
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [31:0] d, input logic [31:0] hc);
        fif.if_req  = 1'b1;
        fif.if_addr = a;
        step();
        fif.if_req = 1'b0;
        check("hit if_done", 32'(fif.if_done), 32'd1);
        check("hit if_inst", fif.if_inst, d);
        check("hit no mem_req", 32'(mif.mem_req), 32'd0);
        check("hit hit_cnt", hit_cnt, hc);
        step();
        check("hit done pulse", 32'(fif.if_done), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        clk          = 1'b0;
        rst          = 1'b0;
        rdy          = 1'b1;
        fif.if_req   = 1'b0;
        fif.if_addr  = '0;
        fif.flush    = 1'b0;
        mif.mem_inst = '0;
        mif.mem_done = 1'b0;

        #12;
        check("rst if_done", 32'(fif.if_done), 32'd0);
        check("rst if_inst", fif.if_inst, 32'd0);
        check("rst mem_req", 32'(mif.mem_req), 32'd0);
        check("rst mem_addr", mif.mem_addr, 32'd0);
        check("rst hit_cnt", hit_cnt, 32'd0);
        check("rst miss_cnt", miss_cnt, 32'd0);
        step();
        rst = 1'b1;
        step();

        // 1: cold miss, 2: hit
        do_fill(32'h0000_0004, 32'h0050_0093, 32'd1);
        do_hit(32'h0000_0004, 32'h0050_0093, 32'd1);

        // 3: conflict on index 1 evicts, then the original misses again
        do_fill(32'h0000_0204, 32'h1111_1111, 32'd2);
        do_fill(32'h0000_0004, 32'h0050_0093, 32'd3);

        // 4: flush during a miss drops the word but still fills the line
        fif.if_req  = 1'b1;
        fif.if_addr = 32'h0000_0080;
        step();
        check("flush mem_req", 32'(mif.mem_req), 32'd1);
        step();
        fif.flush = 1'b1;
        step();
        fif.flush    = 1'b0;
        mif.mem_inst = 32'hDEAD_BEEF;
        mif.mem_done = 1'b1;
        step();
        mif.mem_done = 1'b0;
        fif.if_req   = 1'b0;
        check("flush no if_done", 32'(fif.if_done), 32'd0);
        check("flush mem_req drop", 32'(mif.mem_req), 32'd0);
        check("flush miss_cnt", miss_cnt, 32'd4);
        step();
        check("flush still no done", 32'(fif.if_done), 32'd0);
        do_hit(32'h0000_0080, 32'hDEAD_BEEF, 32'd2);

        // flush beats a hitting request in IDLE
        fif.if_req  = 1'b1;
        fif.if_addr = 32'h0000_0080;
        fif.flush   = 1'b1;
        step();
        fif.if_req = 1'b0;
        fif.flush  = 1'b0;
        check("idle flush no done", 32'(fif.if_done), 32'd0);
        check("idle flush hit_cnt", hit_cnt, 32'd2);

        // 5: stall while in MISS, mem_done during the stall is ignored
        fif.if_req  = 1'b1;
        fif.if_addr = 32'h0000_0100;
        step();
        check("stall mem_req", 32'(mif.mem_req), 32'd1);
        rdy = 1'b0;
        step();
        mif.mem_inst = 32'hBAD0_BAD0;
        mif.mem_done = 1'b1;
        step();
        mif.mem_done = 1'b0;
        step();
        check("stall mem_req held", 32'(mif.mem_req), 32'd1);
        check("stall no done", 32'(fif.if_done), 32'd0);
        rdy = 1'b1;
        step();
        check("post-stall mem_req", 32'(mif.mem_req), 32'd1);
        check("post-stall no done", 32'(fif.if_done), 32'd0);
        mif.mem_inst = 32'h1234_5678;
        mif.mem_done = 1'b1;
        step();
        mif.mem_done = 1'b0;
        fif.if_req   = 1'b0;
        check("stall fill done", 32'(fif.if_done), 32'd1);
        check("stall fill inst", fif.if_inst, 32'h1234_5678);
        check("stall miss_cnt", miss_cnt, 32'd5);
        step();
        do_hit(32'h0000_0100, 32'h1234_5678, 32'd3);

        // 6: async reset mid-fill
        fif.if_req  = 1'b1;
        fif.if_addr = 32'h0000_0180;
        step();
        check("pre-rst mem_req", 32'(mif.mem_req), 32'd1);
        #2;
        rst        = 1'b0;
        fif.if_req = 1'b0;
        #1;
        check("async rst mem_req", 32'(mif.mem_req), 32'd0);
        check("async rst if_done", 32'(fif.if_done), 32'd0);
        check("async rst hit_cnt", hit_cnt, 32'd0);
        check("async rst miss_cnt", miss_cnt, 32'd0);
        step();
        rst = 1'b1;
        step();
        do_fill(32'h0000_0080, 32'hCAFE_F00D, 32'd1);
        do_fill(32'h0000_0180, 32'h0BAD_F00D, 32'd2);
        check("final hit_cnt", hit_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
